shift_exec_pipe: RTL and testbench

//  Two-stage pipelined shift execution unit for the RV32I datapath (SLL/SRL/SRA, incl. SLLI/SRLI/SRAI).

---
 rtl/shift_pkg.sv | 39 +++
 rtl/shift_left_logical.sv | 23 ++
 rtl/shift_pipe_reg.sv | 41 ++++
 rtl/shift_right_arithmetic.sv | 23 ++
 rtl/shift_right_logical.sv | 23 ++
 rtl/shift_exec_pipe.sv | 120 ++++++++++++
 tb/tb_shift_exec_pipe.sv | 299 +++++++++++++++++++++++++++++
 7 files changed

// File: rtl/shift_pkg.sv
// Shared types, encodings and op decode for the RV32I shift execution pipe.
// Latency: n/a (package only).
// Backpressure: n/a.
package shift_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;  // SRL / SRA, split by instr[30]

  typedef enum logic [1:0] {SH_SLL, SH_SRL, SH_SRA, SH_ILL} shift_op_t;

  // S1 payload: operand, shift amount and decoded op.
  typedef struct packed {
    logic               ill;
    shift_op_t          op;
    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    a;
  } s1_dat_t;

  // S2 payload: selected shifter result plus illegal flag.
  typedef struct packed {
    logic            ill;
    logic [XLEN-1:0] res;
  } s2_dat_t;

  function automatic shift_op_t decode_shift(input logic [2:0] funct3, input logic f7_5);
    shift_op_t op;
    op = SH_ILL;
    if (funct3 == F3_SLL && !f7_5) begin
      op = SH_SLL;
    end else if (funct3 == F3_SRX) begin
      op = f7_5 ? SH_SRA : SH_SRL;
    end
    return op;
  endfunction

endpackage

// File: rtl/shift_left_logical.sv
// Mux-based logical left shifter, zero fill.
// Latency: combinational.
// Backpressure: n/a.
// Ports: i_a value, i_shamt amount, o_y result.
module shift_left_logical #(
  parameter int N = 32
) (
  input  logic [N-1:0]         i_a,
  input  logic [$clog2(N)-1:0] i_shamt,
  output logic [N-1:0]         o_y
);

  localparam int S = $clog2(N);

  logic [N-1:0] w_stg [0:S];

  assign w_stg[0] = i_a;
  for (genvar k = 0; k < S; k++) begin : g_stg
    assign w_stg[k+1] = i_shamt[k] ? (w_stg[k] << (2**k)) : w_stg[k];
  end
  assign o_y = w_stg[S];

endmodule

// File: rtl/shift_pipe_reg.sv
// Generic valid/ready pipeline register, W bits of payload.
// Latency: 1 cycle from input handshake to o_vld.
// Backpressure: holds payload stable while o_vld & !i_rdy; o_rdy = !full | i_rdy.
// Ports: clk/rst (sync, active-high); i_vld/o_rdy/i_dat upstream; o_vld/i_rdy/o_dat downstream.
module shift_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_vld,
  output logic         o_rdy,
  input  logic [W-1:0] i_dat,
  output logic         o_vld,
  input  logic         i_rdy,
  output logic [W-1:0] o_dat
);

  logic         r_vld;
  logic [W-1:0] r_dat;
  logic         w_load;

  // Accept when empty, or when the current content leaves this same cycle.
  assign o_rdy  = !r_vld || i_rdy;
  assign w_load = i_vld && o_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else if (w_load) begin
      r_vld <= 1'b1;
      r_dat <= i_dat;
    end else if (i_rdy) begin
      r_vld <= 1'b0;
    end
  end

  assign o_vld = r_vld;
  assign o_dat = r_dat;

endmodule

// File: rtl/shift_right_arithmetic.sv
// Mux-based arithmetic right shifter, fills with the sign bit.
// Latency: combinational.
// Backpressure: n/a.
// Ports: i_a value, i_shamt amount, o_y result.
module shift_right_arithmetic #(
  parameter int N = 32
) (
  input  logic [N-1:0]         i_a,
  input  logic [$clog2(N)-1:0] i_shamt,
  output logic [N-1:0]         o_y
);

  localparam int S = $clog2(N);

  logic [N-1:0] w_stg [0:S];

  assign w_stg[0] = i_a;
  for (genvar k = 0; k < S; k++) begin : g_stg
    assign w_stg[k+1] = i_shamt[k] ? $unsigned($signed(w_stg[k]) >>> (2**k)) : w_stg[k];
  end
  assign o_y = w_stg[S];

endmodule

// File: rtl/shift_right_logical.sv
// Mux-based logical right shifter, zero fill.
// Latency: combinational.
// Backpressure: n/a.
// Ports: i_a value, i_shamt amount, o_y result.
module shift_right_logical #(
  parameter int N = 32
) (
  input  logic [N-1:0]         i_a,
  input  logic [$clog2(N)-1:0] i_shamt,
  output logic [N-1:0]         o_y
);

  localparam int S = $clog2(N);

  logic [N-1:0] w_stg [0:S];

  assign w_stg[0] = i_a;
  for (genvar k = 0; k < S; k++) begin : g_stg
    assign w_stg[k+1] = i_shamt[k] ? (w_stg[k] >> (2**k)) : w_stg[k];
  end
  assign o_y = w_stg[S];

endmodule

// File: rtl/shift_exec_pipe.sv
// Two-stage RV32I shift unit (SLL/SRL/SRA and immediate forms) with saturating op counter.
// Latency: 2 edges from input handshake to out_valid (S1 then S2), 1 op/cycle sustained.
// Backpressure: stalls hold S2 and a full S1; in_ready is combinational from out_ready.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_a/in_b/in_funct3/in_funct7_5 upstream;
//        out_valid/out_ready/out_result/out_illegal downstream; op_count = completed output transfers.
module shift_exec_pipe
  import shift_pkg::*;
#(
  parameter int N     = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic [2:0]       in_funct3,
  input  logic             in_funct7_5,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_result,
  output logic             out_illegal,
  output logic [CNT_W-1:0] op_count
);

  shift_op_t       w_op;
  s1_dat_t         w_s1_in_dat;
  s1_dat_t         w_s1_dat;
  logic            w_s1_vld;
  logic            w_s2_rdy;
  s2_dat_t         w_s2_in_dat;
  s2_dat_t         w_s2_dat;
  logic            w_out_vld;
  logic [XLEN-1:0] w_sll;
  logic [XLEN-1:0] w_srl;
  logic [XLEN-1:0] w_sra;
  logic [CNT_W-1:0] r_op_count;

  // Only the low five bits of the shift source matter for RV32I.
  logic w_unused_b_hi;
  assign w_unused_b_hi = ^in_b[N-1:SHAMT_W];

  assign w_op = decode_shift(in_funct3, in_funct7_5);

  always_comb begin
    w_s1_in_dat       = '0;
    w_s1_in_dat.ill   = (w_op == SH_ILL);
    w_s1_in_dat.op    = w_op;
    w_s1_in_dat.shamt = in_b[SHAMT_W-1:0];
    w_s1_in_dat.a     = in_a;
  end

  shift_pipe_reg #(.W($bits(s1_dat_t))) u_s1 (
    .clk   (clk),
    .rst   (rst),
    .i_vld (in_valid),
    .o_rdy (in_ready),
    .i_dat (w_s1_in_dat),
    .o_vld (w_s1_vld),
    .i_rdy (w_s2_rdy),
    .o_dat (w_s1_dat)
  );

  shift_left_logical #(.N(XLEN)) u_sll (
    .i_a     (w_s1_dat.a),
    .i_shamt (w_s1_dat.shamt),
    .o_y     (w_sll)
  );

  shift_right_logical #(.N(XLEN)) u_srl (
    .i_a     (w_s1_dat.a),
    .i_shamt (w_s1_dat.shamt),
    .o_y     (w_srl)
  );

  shift_right_arithmetic #(.N(XLEN)) u_sra (
    .i_a     (w_s1_dat.a),
    .i_shamt (w_s1_dat.shamt),
    .o_y     (w_sra)
  );

  // Illegal encodings carry a zero result so downstream never sees stale operand data.
  always_comb begin
    w_s2_in_dat     = '0;
    w_s2_in_dat.ill = w_s1_dat.ill;
    case (w_s1_dat.op)
      SH_SLL:  w_s2_in_dat.res = w_sll;
      SH_SRL:  w_s2_in_dat.res = w_srl;
      SH_SRA:  w_s2_in_dat.res = w_sra;
      default: w_s2_in_dat.res = '0;
    endcase
  end

  shift_pipe_reg #(.W($bits(s2_dat_t))) u_s2 (
    .clk   (clk),
    .rst   (rst),
    .i_vld (w_s1_vld),
    .o_rdy (w_s2_rdy),
    .i_dat (w_s2_in_dat),
    .o_vld (w_out_vld),
    .i_rdy (out_ready),
    .o_dat (w_s2_dat)
  );

  // Saturating count of output transfers; holds at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (w_out_vld && out_ready && (r_op_count != {CNT_W{1'b1}})) begin
      r_op_count <= r_op_count + 1'b1;
    end
  end

  assign out_valid   = w_out_vld;
  assign out_result  = w_s2_dat.res;
  assign out_illegal = w_s2_dat.ill;
  assign op_count    = r_op_count;

endmodule

// File: tb/tb_shift_exec_pipe.sv
module tb_shift_exec_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_funct3;
  logic        in_funct7_5;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_illegal;
  logic [15:0] op_count;

  always #5 clk = ~clk;

  shift_exec_pipe #(.N(32), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_funct3   (in_funct3),
    .in_funct7_5 (in_funct7_5),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_illegal (out_illegal),
    .op_count    (op_count)
  );

  typedef struct {
    logic [31:0] res;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   pop_cyc[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cnt = 0;
  int   cyc     = 0;
  bit   rnd_bp  = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour straight from the RV32I shift rules.
  function automatic exp_t ref_model(input logic [31:0] a, input logic [31:0] b,
                                     input logic [2:0] f3, input logic f7);
    exp_t e;
    int   sh;
    sh    = int'(b % 32);
    e.res = 32'h0;
    e.ill = 1'b0;
    if (f3 == 3'b001 && !f7)      e.res = a << sh;
    else if (f3 == 3'b101 && !f7) e.res = a >> sh;
    else if (f3 == 3'b101 && f7)  e.res = $unsigned($signed(a) >>> sh);
    else                          e.ill = 1'b1;
    return e;
  endfunction

  task automatic send_x(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                        input logic f7, input exp_t e);
    bit done;
    done        = 0;
    in_a        = a;
    in_b        = b;
    in_funct3   = f3;
    in_funct7_5 = f7;
    in_valid    = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(e);
        done = 1;
      end
      @(posedge clk);
      #1;
      if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: in_ready never seen for a=%h", a);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3, input logic f7);
    send_x(a, b, f3, f7, ref_model(a, b, f3, f7));
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic i);
    exp_t e;
    e.res = r;
    e.ill = i;
    return e;
  endfunction

  task automatic wait_drain();
    for (int i = 0; i < 1000 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results still outstanding", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    exp_cnt = 0;
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks stall stability.
  initial begin
    logic        prev_stall;
    logic        prev_rst;
    logic [31:0] prev_res;
    logic        prev_ill;
    exp_t        e;
    prev_stall = 1'b0;
    prev_rst   = 1'b1;
    prev_res   = 32'h0;
    prev_ill   = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_stall && !prev_rst) begin
        check("hold_result", out_result, prev_res);
        check("hold_illegal", {31'b0, out_illegal}, {31'b0, prev_ill});
      end
      if (out_valid && out_ready && !rst) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: result %h illegal %b with nothing outstanding", out_result, out_illegal);
        end else begin
          e = q.pop_front();
          check("result", out_result, e.res);
          check("illegal", {31'b0, out_illegal}, {31'b0, e.ill});
        end
        check("op_count_run", {16'b0, op_count}, exp_cnt);
        if (exp_cnt < 65535) exp_cnt++;
        pop_cyc.push_back(cyc);
      end
      prev_stall = out_valid && !out_ready;
      prev_rst   = rst;
      prev_res   = out_result;
      prev_ill   = out_illegal;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    int          d;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_a        = 32'h0;
    in_b        = 32'h0;
    in_funct3   = 3'b0;
    in_funct7_5 = 1'b0;
    out_ready   = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_result", out_result, 32'h0);
    check("rst_out_illegal", {31'b0, out_illegal}, 32'd0);
    check("rst_op_count", {16'b0, op_count}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    rst = 1'b0;

    // 1: SRL 0x80000000 >> 31; S1 after the accept edge, S2/out_valid after the next.
    send_x(32'h8000_0000, 32'd31, 3'b101, 1'b0, mk(32'h0000_0001, 1'b0));
    check("t1_valid_after_accept", {31'b0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("t1_valid_next_edge", {31'b0, out_valid}, 32'd1);
    check("t1_result", out_result, 32'h0000_0001);
    wait_drain();

    // 2: back-to-back SRA then SLL, results on consecutive cycles.
    pop_cyc.delete();
    send_x(32'h8000_0000, 32'd4, 3'b101, 1'b1, mk(32'hF800_0000, 1'b0));
    send_x(32'h0000_0001, 32'd31, 3'b001, 1'b0, mk(32'h8000_0000, 1'b0));
    wait_drain();
    check("t2_pop_count", pop_cyc.size(), 32'd2);
    d = (pop_cyc.size() == 2) ? (pop_cyc[1] - pop_cyc[0]) : -1;
    check("t2_consecutive", d, 32'd1);

    // 3: upper shift-source bits ignored; shamt=0 passes through.
    send_x(32'hF000_0000, 32'hFFFF_FFE3, 3'b101, 1'b0, mk(32'h1E00_0000, 1'b0));
    send_x(32'h1234_5678, 32'h0000_0020, 3'b001, 1'b0, mk(32'h1234_5678, 1'b0));
    send_x(32'h8765_4321, 32'h0000_0000, 3'b101, 1'b1, mk(32'h8765_4321, 1'b0));
    wait_drain();

    // 4: downstream stall while pushing three ops.
    do_reset();
    out_ready = 1'b0;
    send_x(32'h0000_00F0, 32'd4, 3'b001, 1'b0, mk(32'h0000_0F00, 1'b0));
    send_x(32'h0000_00F0, 32'd4, 3'b101, 1'b0, mk(32'h0000_000F, 1'b0));
    in_a        = 32'hC000_0000;
    in_b        = 32'd1;
    in_funct3   = 3'b101;
    in_funct7_5 = 1'b1;
    in_valid    = 1'b1;
    @(negedge clk);
    held = out_result;
    check("t4_stalled_valid", {31'b0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      check("t4_in_ready_low", {31'b0, in_ready}, 32'd0);
      check("t4_result_stable", out_result, held);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send_x(32'hC000_0000, 32'd1, 3'b101, 1'b1, mk(32'hE000_0000, 1'b0));
    wait_drain();
    check("t4_op_count", {16'b0, op_count}, 32'd3);

    // 5: illegal encodings.
    do_reset();
    send_x(32'hDEAD_BEEF, 32'd5, 3'b000, 1'b0, mk(32'h0, 1'b1));
    send_x(32'hDEAD_BEEF, 32'd5, 3'b001, 1'b1, mk(32'h0, 1'b1));
    wait_drain();
    check("t5_op_count", {16'b0, op_count}, 32'd2);

    // 6: reset with both stages full and output stalled.
    out_ready = 1'b0;
    send(32'h1111_1111, 32'd3, 3'b001, 1'b0);
    send(32'h2222_2222, 32'd3, 3'b101, 1'b0);
    do_reset();
    check("t6_out_valid", {31'b0, out_valid}, 32'd0);
    check("t6_in_ready", {31'b0, in_ready}, 32'd1);
    check("t6_op_count", {16'b0, op_count}, 32'd0);
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("t6_no_ghost", {31'b0, out_valid}, 32'd0);
    send(32'hA5A5_A5A5, 32'd8, 3'b101, 1'b1);
    wait_drain();

    // Random traffic with random downstream backpressure.
    do_reset();
    rnd_bp = 1;
    for (int n = 0; n < 300; n++) begin
      logic [2:0] f3;
      logic       f7;
      int         r;
      r = $urandom_range(0, 7);
      if (r < 3) begin
        f3 = 3'b001;
        f7 = ($urandom_range(0, 5) == 0);
      end else if (r < 6) begin
        f3 = 3'b101;
        f7 = $urandom_range(0, 1) == 1;
      end else begin
        f3 = 3'($urandom_range(0, 7));
        f7 = $urandom_range(0, 1) == 1;
      end
      send($urandom, $urandom, f3, f7);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1 out_ready = ($urandom_range(0, 3) != 0);
      end
    end
    rnd_bp    = 0;
    out_ready = 1'b1;
    wait_drain();
    check("rand_op_count", {16'b0, op_count}, 32'd300);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
